relu_maxpool_stream: RTL and testbench

RELU_MAXPOOL_STREAM -- requirements
Module: relu_maxpool_stream

---
 rtl/relu_maxpool_stream.sv | 152 +++++++++++++++
 tb/tb_relu_maxpool_stream.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_stream.sv
// relu_maxpool_stream: streaming ReLU followed by 2x2/stride-2 max pooling.
// Samples arrive in raster order (column, then row, then channel). Even rows
// fold horizontal pairs into a half-width line buffer, and odd rows combine
// those entries with their own pairs to produce one pooled sample per 2x2
// window. A single output register provides valid/ready handshaking, and the
// input is stalled whenever that register is full and not being drained.
module relu_maxpool_stream #(
    parameter int DATA_WIDTH = 18,
    parameter int FRAC_WIDTH = 8,
    parameter int H_IN       = 5,
    parameter int W_IN       = 5,
    parameter int N_CH       = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         frame_done
);

    localparam int H_P = H_IN / 2;
    localparam int W_P = W_IN / 2;
    localparam int CW  = $clog2(W_IN);
    localparam int RW  = $clog2(H_IN);
    localparam int NW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int LW  = (W_P > 1) ? $clog2(W_P) : 1;

    localparam logic [CW-1:0] COL_MAX  = CW'(W_IN - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(2 * W_P - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(H_IN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(2 * H_P - 1);
    localparam logic [NW-1:0] CH_MAX   = NW'(N_CH - 1);

    // Fixed-point format only travels with the data; reject geometries the
    // pooling window cannot cover.
    if (FRAC_WIDTH >= DATA_WIDTH || H_IN < 2 || W_IN < 2 || N_CH < 1) begin : g_bad_params
        $error("relu_maxpool_stream: illegal parameter combination");
    end

    function automatic logic signed [DATA_WIDTH-1:0] relu(
        input logic signed [DATA_WIDTH-1:0] x
    );
        return x[DATA_WIDTH-1] ? '0 : x;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]                 col;
    logic [RW-1:0]                 row;
    logic [NW-1:0]                 ch;
    logic signed [DATA_WIDTH-1:0]  tmp;
    logic signed [DATA_WIDTH-1:0]  linebuf [W_P];

    logic                          accept;
    logic                          in_pool;
    logic                          pool_fire;
    logic                          frame_last;
    logic [LW-1:0]                 lb_idx;
    logic signed [DATA_WIDTH-1:0]  r_p0;

    logic                          vld_p1;
    logic                          last_p1;
    logic signed [DATA_WIDTH-1:0]  out_data_p1;

    // ---- stage p0: accept, clamp and classify the incoming sample ----
    assign in_ready   = !vld_p1 || out_ready;
    assign accept     = in_valid && in_ready;
    assign r_p0       = relu(in_data);
    // Trailing odd column/row have no partner and fall outside every window.
    assign in_pool    = (col <= COL_LAST) && (row <= ROW_LAST);
    assign lb_idx     = LW'(col >> 1);
    assign pool_fire  = accept && in_pool && row[0] && col[0];
    assign frame_last = (ch == CH_MAX) && (row == ROW_LAST) && (col == COL_LAST);

    // Raster position counters, advanced only by accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (accept) begin
            if (col == COL_MAX) begin
                col <= '0;
                if (row == ROW_MAX) begin
                    row <= '0;
                    ch  <= (ch == CH_MAX) ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Left-column partial: raw sample on even rows, merged with the line
    // buffer entry above it on odd rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmp <= '0;
        end else if (accept && in_pool && !col[0]) begin
            tmp <= row[0] ? smax(linebuf[lb_idx], r_p0) : r_p0;
        end
    end

    // Even rows store the horizontal pair maximum for the odd row below.
    always_ff @(posedge clk) begin
        if (accept && in_pool && !row[0] && col[0]) begin
            linebuf[lb_idx] <= smax(tmp, r_p0);
        end
    end

    // ---- stage p1: pooled result register with valid/ready hold ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            out_data_p1 <= '0;
        end else if (pool_fire) begin
            vld_p1      <= 1'b1;
            last_p1     <= frame_last;
            out_data_p1 <= smax(tmp, r_p0);
        end else if (out_ready) begin
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
        end
    end

    // ---- stage p2: end-of-frame pulse once the last sample is taken ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= vld_p1 && out_ready && last_p1;
        end
    end

    assign out_valid = vld_p1;
    assign out_last  = last_p1;
    assign out_data  = out_data_p1;

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Bench for relu_maxpool_stream: four instances with different geometries
// share the stimulus bus; one is selected at a time. Directed vectors come
// from a table, stall and mid-frame reset are hand-written sequences, and
// random frames are checked against a window-maximum reference model.
module tb_relu_maxpool_stream;

    localparam int DW = 18;
    typedef logic signed [DW-1:0] s_t;

    typedef struct {
        logic [1:0] sel;
        int         pat;
        int         n_exp;
        int         exp_v [8];
    } vec_t;

    function automatic int cfg_h(input int g);
        case (g)
            0: return 4;
            1: return 5;
            2: return 4;
            default: return 7;
        endcase
    endfunction

    function automatic int cfg_w(input int g);
        case (g)
            0: return 4;
            1: return 5;
            2: return 4;
            default: return 6;
        endcase
    endfunction

    function automatic int cfg_n(input int g);
        case (g)
            0: return 1;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    s_t         in_data;
    logic       out_ready;
    logic [1:0] sel;

    logic ir [4];
    logic ov [4];
    logic ol [4];
    logic fdn [4];
    s_t   od [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        relu_maxpool_stream #(
            .DATA_WIDTH(DW),
            .FRAC_WIDTH(8),
            .H_IN(cfg_h(g)),
            .W_IN(cfg_w(g)),
            .N_CH(cfg_n(g))
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(in_valid && (sel == 2'(g))),
            .in_ready(ir[g]),
            .in_data(in_data),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_data(od[g]),
            .out_last(ol[g]),
            .frame_done(fdn[g])
        );
    end

    logic cur_ir, cur_ov, cur_ol, cur_fd;
    s_t   cur_od;
    always_comb begin
        cur_ir = ir[sel];
        cur_ov = ov[sel];
        cur_ol = ol[sel];
        cur_fd = fdn[sel];
        cur_od = od[sel];
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    s_t   in_q [$];
    s_t   exp_d [$];
    logic exp_l [$];
    s_t   got_d [$];
    logic got_l [$];
    int   rdy_mode = 0;
    logic mon_en = 1'b0;
    logic fd_exp = 1'b0;
    logic hold_prev = 1'b0;
    s_t   hold_d;
    logic hold_l;
    int   fd_cnt = 0;
    int   fd_bad = 0;
    int   hold_bad = 0;

    task automatic cmp(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Downstream ready policy: always ready, random, or left to a scenario.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: captures handshakes, checks hold and frame_done timing.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cur_fd !== fd_exp) fd_bad++;
            if (cur_fd) fd_cnt++;
            fd_exp = cur_ov && out_ready && cur_ol;
            if (hold_prev && (!cur_ov || cur_od !== hold_d || cur_ol !== hold_l)) hold_bad++;
            hold_prev = cur_ov && !out_ready;
            hold_d = cur_od;
            hold_l = cur_ol;
            if (cur_ov && out_ready) begin
                got_d.push_back(cur_od);
                got_l.push_back(cur_ol);
            end
        end else begin
            fd_exp = 1'b0;
            hold_prev = 1'b0;
        end
    end

    function automatic s_t gen(input int pat, input int idx);
        int r, c;
        case (pat)
            0: return s_t'((idx % 16 + 1) * 256 + (idx / 16) * 4096);
            1: return s_t'(-512);
            default: begin
                r = (idx / 5) % 5;
                c = idx % 5;
                return (r == 4 || c == 4) ? s_t'(25600) : s_t'(256);
            end
        endcase
    endfunction

    // Reference: every window maximum of the clamped samples, frame by frame.
    task automatic build_expected(input int s, input int frames);
        int h, w, n, base;
        s_t m, v;
        h = cfg_h(s);
        w = cfg_w(s);
        n = cfg_n(s);
        exp_d.delete();
        exp_l.delete();
        for (int f = 0; f < frames; f++) begin
            base = f * n * h * w;
            for (int c = 0; c < n; c++)
                for (int pr = 0; pr < h / 2; pr++)
                    for (int pc = 0; pc < w / 2; pc++) begin
                        m = '0;
                        for (int dy = 0; dy < 2; dy++)
                            for (int dx = 0; dx < 2; dx++) begin
                                v = in_q[base + (c * h + 2 * pr + dy) * w + 2 * pc + dx];
                                if (v > m) m = v;
                            end
                        exp_d.push_back(m);
                        exp_l.push_back(c == n - 1 && pr == h / 2 - 1 && pc == w / 2 - 1);
                    end
        end
    endtask

    task automatic clear_mon();
        mon_en = 1'b0;
        got_d.delete();
        got_l.delete();
        fd_cnt = 0;
        fd_bad = 0;
        hold_bad = 0;
    endtask

    // Reset all instances and select one; leaves the bench at posedge+1.
    task automatic start(input logic [1:0] s);
        clear_mon();
        rst_n = 1'b0;
        in_valid = 1'b0;
        sel = s;
        rdy_mode = 0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic send_all(input int gap_max);
        int n;
        foreach (in_q[i]) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data = in_q[i];
            n = 0;
            @(negedge clk);
            while (!cur_ir && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!cur_ir) begin
                n_cmp++;
                n_bad++;
                $display("FAIL in_ready_timeout: got 0 expected 1 at sample %0d", i);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_run(input string nm, input int frames);
        int n;
        int k;
        n = 0;
        while (got_d.size() < exp_d.size() && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        cmp({nm, "_count"}, got_d.size(), exp_d.size());
        k = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < k; i++) begin
            cmp($sformatf("%s_data[%0d]", nm, i), got_d[i], exp_d[i]);
            cmp($sformatf("%s_last[%0d]", nm, i), got_l[i], exp_l[i]);
        end
        cmp({nm, "_frame_done_count"}, fd_cnt, frames);
        cmp({nm, "_frame_done_timing"}, fd_bad, 0);
        cmp({nm, "_hold_stable"}, hold_bad, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt [4];
        s_t   held;
        int   n;

        vt[0].sel = 2'd0; vt[0].pat = 0; vt[0].n_exp = 4;
        vt[0].exp_v = '{1536, 2048, 3584, 4096, 0, 0, 0, 0};
        vt[1].sel = 2'd1; vt[1].pat = 1; vt[1].n_exp = 4;
        vt[1].exp_v = '{0, 0, 0, 0, 0, 0, 0, 0};
        vt[2].sel = 2'd1; vt[2].pat = 2; vt[2].n_exp = 4;
        vt[2].exp_v = '{256, 256, 256, 256, 0, 0, 0, 0};
        vt[3].sel = 2'd2; vt[3].pat = 0; vt[3].n_exp = 8;
        vt[3].exp_v = '{1536, 2048, 3584, 4096, 5632, 6144, 7680, 8192};

        // Reset state of every instance, observed while rst_n is low.
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        sel = 2'd0;
        #12;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            cmp($sformatf("reset_out_valid[%0d]", k), cur_ov, 0);
            cmp($sformatf("reset_out_data[%0d]", k), cur_od, 0);
            cmp($sformatf("reset_out_last[%0d]", k), cur_ol, 0);
            cmp($sformatf("reset_frame_done[%0d]", k), cur_fd, 0);
            cmp($sformatf("reset_in_ready[%0d]", k), cur_ir, 1);
        end

        // Table-driven directed frames.
        for (int t = 0; t < 4; t++) begin
            start(vt[t].sel);
            in_q.delete();
            for (int i = 0; i < cfg_h(vt[t].sel) * cfg_w(vt[t].sel) * cfg_n(vt[t].sel); i++)
                in_q.push_back(gen(vt[t].pat, i));
            exp_d.delete();
            exp_l.delete();
            for (int i = 0; i < vt[t].n_exp; i++) begin
                exp_d.push_back(s_t'(vt[t].exp_v[i]));
                exp_l.push_back(i == vt[t].n_exp - 1);
            end
            send_all(0);
            check_run($sformatf("vec%0d", t), 1);
        end

        // Downstream stall for 10 cycles with the first result pending.
        start(2'd0);
        in_q.delete();
        for (int i = 0; i < 16; i++) in_q.push_back(gen(0, i));
        build_expected(0, 1);
        fork
            send_all(0);
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #2;
                    n++;
                end while (!cur_ov && n < 200);
                if (!cur_ov) begin
                    cmp("stall_wait_valid", cur_ov, 1);
                end else begin
                    rdy_mode = 2;
                    out_ready = 1'b0;
                    held = exp_d[0];
                    repeat (10) begin
                        @(negedge clk);
                        cmp("stall_out_valid", cur_ov, 1);
                        cmp("stall_out_data", cur_od, held);
                        cmp("stall_in_ready", cur_ir, 0);
                    end
                    @(posedge clk);
                    #2;
                    out_ready = 1'b1;
                    rdy_mode = 0;
                end
            end
        join
        check_run("stall", 1);

        // Reset in the middle of a frame, then a clean frame.
        start(2'd0);
        in_q.delete();
        for (int i = 0; i < 7; i++) in_q.push_back(gen(0, i));
        send_all(0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        cmp("midreset_out_valid", cur_ov, 0);
        cmp("midreset_out_data", cur_od, 0);
        cmp("midreset_out_last", cur_ol, 0);
        cmp("midreset_frame_done", cur_fd, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        mon_en = 1'b1;
        in_q.delete();
        for (int i = 0; i < 16; i++) in_q.push_back(gen(0, i));
        build_expected(0, 1);
        send_all(0);
        check_run("after_reset", 1);

        // Random frames with random gaps and random backpressure.
        for (int k = 0; k < 3; k++) begin
            logic [1:0] s;
            int frames;
            s = (k == 0) ? 2'd3 : (k == 1) ? 2'd1 : 2'd2;
            frames = (k == 2) ? 1 : 2;
            start(s);
            in_q.delete();
            for (int i = 0; i < frames * cfg_h(s) * cfg_w(s) * cfg_n(s); i++)
                in_q.push_back(s_t'($urandom_range(0, 262143)));
            build_expected(s, frames);
            rdy_mode = 1;
            send_all(2);
            check_run($sformatf("rand%0d", k), frames);
            rdy_mode = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
